// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch feeding a small {pc, word}
// instruction buffer, with branch redirect and downstream stall.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_din,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    output logic        mem_rd,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fpc;
    logic [1:0]    cnt;
    logic [1:0]    cnt_nxt;
    logic          issue;
    logic          fpc_adv;
    logic          push;
    logic          do_push;
    logic          pop;
    logic          space;
    logic [AW:0]   load;
    logic          cap_vld;
    logic [1:0]    cap_idx;
    logic [23:0]   word;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    // Buffered entries plus the one word being assembled must leave room.
    assign load  = count + {{AW{1'b0}}, (state != IDLE)};
    assign space = (load < DEPTH_C);

    assign mem_rd = issue && rst;
    assign mem_a  = mem_rd ? (fpc + {30'd0, cnt}) : 32'd0;

    assign pop     = inst_valid_o && !stall_i && !redirect_i;
    assign do_push = push && ((count != DEPTH_C) || pop);

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : 32'd0;
    assign pc_o         = inst_valid_o ? fifo_pc[rd_ptr] : 32'd0;

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, byte issue and push decisions; redirect overrides all.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        fpc_adv   = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (space && mem_gnt) begin
                    issue     = 1'b1;
                    cnt_nxt   = 2'd1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (mem_gnt) begin
                    issue = 1'b1;
                    if (cnt == 2'd3) begin
                        fpc_adv   = 1'b1;
                        cnt_nxt   = 2'd0;
                        state_nxt = TAIL;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            TAIL: begin
                push = 1'b1;
                if (space && mem_gnt) begin
                    issue     = 1'b1;
                    cnt_nxt   = 2'd1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect_i) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
            issue     = 1'b0;
            fpc_adv   = 1'b0;
            push      = 1'b0;
        end
    end

    // Fetch pointer and byte counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc <= RESET_PC;
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            if (redirect_i)   fpc <= redirect_pc_i & 32'hFFFF_FFFC;
            else if (fpc_adv) fpc <= fpc + 32'd4;
        end
    end

    // Capture each returned byte one cycle after its read strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld <= 1'b0;
            cap_idx <= 2'd0;
            word    <= 24'd0;
        end else begin
            cap_vld <= mem_rd;
            cap_idx <= cnt;
            if (cap_vld && !redirect_i) begin
                case (cap_idx)
                    2'd0:    word[7:0]   <= mem_din;
                    2'd1:    word[15:8]  <= mem_din;
                    2'd2:    word[23:16] <= mem_din;
                    default: ;
                endcase
            end
        end
    end

    // Buffer pointers and occupancy; redirect empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
        end
    end

    // Buffer storage; byte 3 goes straight from mem_din into the entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_inst[wr_ptr] <= {mem_din, word};
            fifo_pc[wr_ptr]   <= fpc - 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic checked
// against an instruction-stream model of the fetch unit.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FD       = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_din;
    logic        mem_gnt;
    logic [31:0] mem_a;
    logic        mem_rd;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int checks;
    int errors;

    inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .mem_din(mem_din), .mem_gnt(mem_gnt),
        .mem_a(mem_a), .mem_rd(mem_rd), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (a == 32'd0) return 8'h13;
        if (a == 32'd1) return 8'h05;
        if (a == 32'd2) return 8'h10;
        if (a == 32'd3) return 8'h00;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {byte_at(pc + 32'd3), byte_at(pc + 32'd2),
                byte_at(pc + 32'd1), byte_at(pc)};
    endfunction

    // Byte memory: answers a strobed read on the next cycle, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd) mem_din <= byte_at(mem_a);
        else        mem_din <= 8'($urandom);
    end

    task automatic do_reset(input logic g, input logic s);
        @(posedge clk); #2;
        rst = 1'b0; mem_gnt = g; stall_i = s;
        redirect_i = 1'b0; redirect_pc_i = 32'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset;
        @(posedge clk); #2;
        rst = 1'b0; mem_gnt = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks += 5;
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
        if (mem_a !== 32'd0) begin errors++; $display("FAIL rst_mem_a: got %h expected 0", mem_a); end
        if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
        if (inst_o !== 32'd0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
        if (pc_o !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
    endtask

    task automatic test_first_fetch;
        int n;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (mem_rd !== 1'b1) begin errors++; $display("FAIL first_rd: got %b expected 1", mem_rd); end
        if (mem_a !== RESET_PC) begin errors++; $display("FAIL first_addr: got %h expected %h", mem_a, RESET_PC); end
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #3;
            if (inst_valid_o) begin n = c; break; end
        end
        checks += 3;
        if (n != 5) begin errors++; $display("FAIL first_latency: got %0d expected 5", n); end
        if (inst_o !== 32'h0010_0513) begin errors++; $display("FAIL first_inst: got %h expected 00100513", inst_o); end
        if (pc_o !== 32'd0) begin errors++; $display("FAIL first_pc: got %h expected 0", pc_o); end
    endtask

    task automatic test_back_to_back;
        int k;
        int last;
        logic [31:0] ep;
        do_reset(1'b1, 1'b0);
        #1;
        k = 0; last = 0;
        for (int c = 1; c <= 60 && k < 5; c++) begin
            @(posedge clk); #3;
            if (inst_valid_o) begin
                ep = RESET_PC + 32'(4 * k);
                checks += 2;
                if (pc_o !== ep) begin errors++; $display("FAIL b2b_pc: got %h expected %h", pc_o, ep); end
                if (inst_o !== word_at(ep)) begin errors++; $display("FAIL b2b_inst: got %h expected %h", inst_o, word_at(ep)); end
                if (k > 0) begin
                    checks++;
                    if (c - last != 4) begin errors++; $display("FAIL b2b_rate: got %0d cycles expected 4", c - last); end
                end
                last = c;
                k++;
            end
        end
        checks++;
        if (k != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", k); end
    endtask

    task automatic test_stall_fill;
        int reads;
        logic [31:0] ep;
        do_reset(1'b1, 1'b1);
        #1;
        reads = mem_rd ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #3;
            if (mem_rd) reads++;
        end
        checks += 4;
        if (reads != 4 * FD) begin errors++; $display("FAIL fill_reads: got %0d expected %0d", reads, 4 * FD); end
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL fill_rd_idle: got %b expected 0", mem_rd); end
        if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", inst_valid_o); end
        if (pc_o !== RESET_PC) begin errors++; $display("FAIL fill_head: got %h expected %h", pc_o, RESET_PC); end
        stall_i = 1'b0;
        #1;
        for (int i = 0; i < FD; i++) begin
            ep = RESET_PC + 32'(4 * i);
            checks += 2;
            if (inst_valid_o !== 1'b1 || pc_o !== ep) begin errors++; $display("FAIL drain_pc: got %b/%h expected 1/%h", inst_valid_o, pc_o, ep); end
            if (inst_o !== word_at(ep)) begin errors++; $display("FAIL drain_inst: got %h expected %h", inst_o, word_at(ep)); end
            @(posedge clk); #3;
        end
    endtask

    task automatic test_gnt_toggle;
        int k;
        int last;
        logic [31:0] ep;
        do_reset(1'b1, 1'b0);
        #1;
        k = 0; last = 0;
        for (int c = 1; c <= 80 && k < 3; c++) begin
            @(posedge clk); #2;
            mem_gnt = ~mem_gnt;
            #1;
            if (mem_rd && !mem_gnt) begin
                checks++; errors++;
                $display("FAIL tog_rd_nognt: got mem_rd 1 expected 0");
            end
            if (inst_valid_o) begin
                ep = RESET_PC + 32'(4 * k);
                checks += 2;
                if (pc_o !== ep) begin errors++; $display("FAIL tog_pc: got %h expected %h", pc_o, ep); end
                if (inst_o !== word_at(ep)) begin errors++; $display("FAIL tog_inst: got %h expected %h", inst_o, word_at(ep)); end
                if (k > 0) begin
                    checks++;
                    if (c - last != 8) begin errors++; $display("FAIL tog_rate: got %0d cycles expected 8", c - last); end
                end
                last = c;
                k++;
            end
        end
        checks++;
        if (k != 3) begin errors++; $display("FAIL tog_count: got %0d expected 3", k); end
        mem_gnt = 1'b1;
    endtask

    task automatic test_redirect;
        int found;
        do_reset(1'b1, 1'b0);
        #1;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_rd && mem_a == 32'd2) begin found = 1; break; end
            @(posedge clk); #3;
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_1002;
        #1;
        checks += 2;
        if (found != 1) begin errors++; $display("FAIL redir_byte2: got %0d expected 1", found); end
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd: got %b expected 0", mem_rd); end
        @(posedge clk); #2;
        redirect_i = 1'b0;
        #1;
        checks += 2;
        if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", inst_valid_o); end
        if (mem_rd !== 1'b1 || mem_a !== 32'h0000_1000) begin errors++; $display("FAIL redir_issue: got %b/%h expected 1/00001000", mem_rd, mem_a); end
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #3;
            if (inst_valid_o) begin found = 1; break; end
        end
        checks += 3;
        if (found != 1) begin errors++; $display("FAIL redir_timeout: got 0 expected 1"); end
        if (pc_o !== 32'h0000_1000) begin errors++; $display("FAIL redir_pc: got %h expected 00001000", pc_o); end
        if (inst_o !== word_at(32'h0000_1000)) begin errors++; $display("FAIL redir_inst: got %h expected %h", inst_o, word_at(32'h1000)); end
        // Two redirects in a row: only the second target may emerge.
        @(posedge clk); #2;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000;
        @(posedge clk); #2;
        redirect_pc_i = 32'h0000_3001;
        #1;
        checks++;
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir2_rd: got %b expected 0", mem_rd); end
        @(posedge clk); #2;
        redirect_i = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #3;
            if (inst_valid_o) begin found = 1; break; end
        end
        checks += 2;
        if (found != 1) begin errors++; $display("FAIL redir2_timeout: got 0 expected 1"); end
        if (pc_o !== 32'h0000_3000) begin errors++; $display("FAIL redir2_pc: got %h expected 00003000", pc_o); end
    endtask

    task automatic test_wrap;
        logic [31:0] got [5];
        logic [31:0] ea;
        int n;
        int found;
        do_reset(1'b1, 1'b1);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        @(posedge clk); #2;
        redirect_i = 1'b0;
        #1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            if (mem_rd) begin got[n] = mem_a; n++; end
            @(posedge clk); #3;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL wrap_reads: got %0d expected 5", n); end
        for (int i = 0; i < n; i++) begin
            ea = 32'hFFFF_FFFC + 32'(i);
            checks++;
            if (got[i] !== ea) begin errors++; $display("FAIL wrap_addr: got %h expected %h", got[i], ea); end
        end
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (inst_valid_o) begin found = 1; break; end
            @(posedge clk); #3;
        end
        checks += 2;
        if (found != 1 || pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", pc_o); end
        if (inst_o !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_inst: got %h expected %h", inst_o, word_at(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid;
        int found;
        do_reset(1'b1, 1'b1);
        #1;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_rd && mem_a == 32'd9) begin found = 1; break; end
            @(posedge clk); #3;
        end
        checks += 2;
        if (found != 1) begin errors++; $display("FAIL mid_reach: got 0 expected 1"); end
        if (inst_valid_o !== 1'b1 || pc_o !== RESET_PC) begin errors++; $display("FAIL mid_head: got %b/%h expected 1/%h", inst_valid_o, pc_o, RESET_PC); end
        rst = 1'b0;
        #1;
        checks += 4;
        if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", inst_valid_o); end
        if (inst_o !== 32'd0 || pc_o !== 32'd0) begin errors++; $display("FAIL mid_outs: got %h/%h expected 0/0", inst_o, pc_o); end
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL mid_rd: got %b expected 0", mem_rd); end
        if (mem_a !== 32'd0) begin errors++; $display("FAIL mid_addr: got %h expected 0", mem_a); end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_a !== RESET_PC) begin errors++; $display("FAIL mid_restart: got %b/%h expected 1/%h", mem_rd, mem_a, RESET_PC); end
    endtask

    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        logic        prev_hold;
        logic        prev_redirect;
        int          pops;
        do_reset(1'b1, 1'b0);
        exp_pc = RESET_PC;
        prev_pc = 32'd0; prev_inst = 32'd0;
        prev_hold = 1'b0; prev_redirect = 1'b0;
        pops = 0;
        for (int c = 0; c < 1500; c++) begin
            mem_gnt = ($urandom_range(0, 99) < 75);
            stall_i = ($urandom_range(0, 99) < 30);
            if (prev_redirect && $urandom_range(0, 99) < 40) redirect_i = 1'b1;
            else redirect_i = ($urandom_range(0, 99) < 4);
            redirect_pc_i = $urandom;
            #1;
            checks++;
            if (mem_rd && !mem_gnt) begin errors++; $display("FAIL rnd_rd_gnt: got mem_rd 1 with mem_gnt 0"); end
            if (redirect_i) begin
                checks++;
                if (mem_rd !== 1'b0) begin errors++; $display("FAIL rnd_redir_rd: got %b expected 0", mem_rd); end
            end
            if (prev_redirect) begin
                checks++;
                if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_post_redir: got %b expected 0", inst_valid_o); end
            end
            if (prev_hold) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== prev_pc || inst_o !== prev_inst) begin
                    errors++;
                    $display("FAIL rnd_stall_hold: got %b/%h/%h expected 1/%h/%h", inst_valid_o, pc_o, inst_o, prev_pc, prev_inst);
                end
            end
            if (inst_valid_o) begin
                checks += 2;
                if (pc_o !== exp_pc) begin errors++; $display("FAIL rnd_pc: got %h expected %h", pc_o, exp_pc); end
                if (inst_o !== word_at(exp_pc)) begin errors++; $display("FAIL rnd_inst: got %h expected %h", inst_o, word_at(exp_pc)); end
            end
            prev_hold = inst_valid_o && stall_i && !redirect_i;
            prev_pc = pc_o;
            prev_inst = inst_o;
            prev_redirect = redirect_i;
            if (redirect_i) begin
                exp_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (inst_valid_o && !stall_i) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            @(posedge clk); #2;
        end
        redirect_i = 1'b0;
        checks++;
        if (pops < 50) begin errors++; $display("FAIL rnd_progress: got %0d pops expected >= 50", pops); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; mem_din = 8'd0; mem_gnt = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_i = 1'b0;
        test_reset;
        test_first_fetch;
        test_back_to_back;
        test_stall_fill;
        test_gnt_toggle;
        test_redirect;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
